rv2t_trap_controller: RTL
=========================

Name: rv2t_trap_controller

Overview:
- Sequences machine-mode trap entry and `mret` return for the RV2T core.
- Arbitrates simultaneous synchronous exception requests from the pipeline and a pending timer interrupt.
- Drives the CSR file's exception-capture port (activate_exception / is_interrupt / exception_code / exception_PC / exception_addr) and its mstatus.MIE update strobes.
- Hands the pipeline a flush pulse plus a redirect PC (trap vector or mepc), held until the fetch stage acknowledges.

Parameters:
- XLEN, 32, data/CSR width.
- PC_BITWIDTH, 32, PC width.
- EXCEPTION_CODE_BITS, 4, width of the mcause code field.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset; same effect as reset_n, applied at clk edge
- exc_illegal  in  1  illegal instruction (includes CSR-file illegal flag)
- exc_ecall  in  1  ECALL executed
- exc_ebreak  in  1  EBREAK executed
- exc_store_misalign  in  1  misaligned store
- exc_load_misalign  in  1  misaligned load
- exc_pc  in  PC_BITWIDTH  PC of the faulting instruction
- exc_addr  in  PC_BITWIDTH  faulting data address
- next_pc  in  PC_BITWIDTH  PC of the next unexecuted instruction (interrupt return point)
- int_window  in  1  pipeline at an instruction boundary; interrupt may be taken
- mret_req  in  1  MRET executed
- mtip  in  1  timer pending from CSR
- mtie  in  1  mie.MTIE from CSR
- mie  in  1  mstatus.MIE from CSR
- mtvec  in  XLEN  mtvec from CSR
- mepc  in  XLEN  mepc from CSR
- activate_exception  out  1  one-cycle CSR capture strobe
- is_interrupt  out  1  mcause[31]
- exception_code  out  EXCEPTION_CODE_BITS  mcause code
- exception_PC  out  PC_BITWIDTH  value for mepc
- exception_addr  out  PC_BITWIDTH  value for mtval
- mie_clear  out  1  one-cycle strobe: mstatus.MIE <= 0
- mie_restore  out  1  one-cycle strobe: mstatus.MIE <= MPIE
- flush  out  1  one-cycle pipeline flush
- redirect_valid  out  1  redirect PC valid; held until ack
- redirect_pc  out  PC_BITWIDTH  target PC
- redirect_ack  in  1  fetch accepted redirect_pc
- busy  out  1  state != IDLE; pipeline must stall issue

Behaviour:
- Reset (either reset): all outputs 0, state IDLE, capture registers 0.
- States: IDLE, TRAP, RETURN, WAIT_ACK.
- IDLE, checked in this order; first match wins:
  - Any exc_* high: capture code by priority illegal(2) > ecall(11) > ebreak(3) > store_misalign(6) > load_misalign(4). Capture is_interrupt=0, exception_PC=exc_pc, exception_addr=exc_addr for misaligned codes else 0. Go to TRAP.
  - mtip & mtie & mie & int_window: capture code 7, is_interrupt=1, exception_PC=next_pc, exception_addr=0. Go to TRAP.
  - mret_req: go to RETURN.
- Exceptions beat interrupts in the same cycle. mtip is level, so the interrupt is re-evaluated after the trap.
- TRAP (1 cycle):
  - activate_exception=1, mie_clear=1, flush=1.
  - redirect_pc <= mtvec with bits[1:0] forced to 0.
  - Go to WAIT_ACK.
- RETURN (1 cycle):
  - mie_restore=1, flush=1.
  - redirect_pc <= mepc with bit[0] forced to 0.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - redirect_valid=1; redirect_pc stable.
  - On redirect_ack, return to IDLE; redirect_valid drops the next cycle.
  - All exc_*, mret_req and interrupts are ignored here.
- Latency:
  - Request seen at edge N → activate_exception high in cycle N+1.
  - redirect_valid from N+2.
  - Earliest next trap acceptance is at the edge after the ack.
- Output timing: is_interrupt, exception_code, exception_PC and exception_addr are registered and hold their last captured value outside TRAP.
- Reset asserted mid-sequence: immediate return to IDLE; no strobes are emitted.
- mret_req together with an exception: the exception wins and the mret is dropped.
- Interrupt while mie=0 or mtie=0: never taken, stays pending.

Optional Feature:
- Macro: TRAP_VECTORED_MODE_EN.
- Defined: for interrupt traps with mtvec[1:0]==2'b01, redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*exception_code. Synchronous exceptions always use the base address.
- Undefined: redirect_pc is always the base address, and mtvec[1:0] is ignored.

Test Plan:
- exc_ecall=1, exc_pc=0x100, mtvec=0x2000 → N+1: activate_exception=1, code=11, is_interrupt=0, exception_PC=0x100, mie_clear=1, flush=1. Then redirect_valid with redirect_pc=0x2000 held until ack.
- exc_illegal and exc_load_misalign high together, exc_addr=0x33 → code=2, exception_addr=0.
- mtip=mtie=mie=1, int_window=1, next_pc=0x40 → code=7, is_interrupt=1, exception_PC=0x40. With TRAP_VECTORED_MODE_EN and mtvec=0x2001: redirect_pc=0x201C; without the macro: 0x2000.
- mret_req, mepc=0x104 → mie_restore=1, flush=1, redirect_pc=0x104. Hold redirect_ack low 5 cycles: redirect_valid stays high and busy=1 throughout.
- Timer pending with mie=0 for 10 cycles → no activate_exception. Then exception plus interrupt in the same cycle → exception taken first.
- reset_n pulsed low during WAIT_ACK → all outputs 0 immediately. After release, exc_ebreak is accepted normally with code=3.

Source files
------------

// File: rtl/rv2t_trap_controller_if.sv
// rv2t_trap_controller_if: pipeline/CSR <-> trap controller signal bundle.
//   master: pipeline and CSR file side (drives requests, CSR values, redirect_ack)
//   slave : trap controller side (drives CSR capture port, MIE strobes, flush/redirect, busy)
interface rv2t_trap_controller_if #(
   parameter int XLEN                = 32,
   parameter int PC_BITWIDTH         = 32,
   parameter int EXCEPTION_CODE_BITS = 4
);
   logic                           exc_illegal;
   logic                           exc_ecall;
   logic                           exc_ebreak;
   logic                           exc_store_misalign;
   logic                           exc_load_misalign;
   logic [PC_BITWIDTH-1:0]         exc_pc;
   logic [PC_BITWIDTH-1:0]         exc_addr;
   logic [PC_BITWIDTH-1:0]         next_pc;
   logic                           int_window;
   logic                           mret_req;
   logic                           mtip;
   logic                           mtie;
   logic                           mie;
   logic [XLEN-1:0]                mtvec;
   logic [XLEN-1:0]                mepc;
   logic                           activate_exception;
   logic                           is_interrupt;
   logic [EXCEPTION_CODE_BITS-1:0] exception_code;
   logic [PC_BITWIDTH-1:0]         exception_PC;
   logic [PC_BITWIDTH-1:0]         exception_addr;
   logic                           mie_clear;
   logic                           mie_restore;
   logic                           flush;
   logic                           redirect_valid;
   logic [PC_BITWIDTH-1:0]         redirect_pc;
   logic                           redirect_ack;
   logic                           busy;
   modport master (
      output exc_illegal, exc_ecall, exc_ebreak, exc_store_misalign, exc_load_misalign,
      output exc_pc, exc_addr, next_pc, int_window, mret_req, mtip, mtie, mie, mtvec, mepc,
      output redirect_ack,
      input  activate_exception, is_interrupt, exception_code, exception_PC, exception_addr,
      input  mie_clear, mie_restore, flush, redirect_valid, redirect_pc, busy
   );
   modport slave (
      input  exc_illegal, exc_ecall, exc_ebreak, exc_store_misalign, exc_load_misalign,
      input  exc_pc, exc_addr, next_pc, int_window, mret_req, mtip, mtie, mie, mtvec, mepc,
      input  redirect_ack,
      output activate_exception, is_interrupt, exception_code, exception_PC, exception_addr,
      output mie_clear, mie_restore, flush, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/rv2t_trap_controller.sv
// rv2t_trap_controller: machine-mode trap entry / mret return sequencer for RV2T.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   sync_reset : synchronous reset, same effect as reset_n
//   bus        : rv2t_trap_controller_if.slave (exception/interrupt/mret requests, CSR
//                values in; CSR capture port, MIE strobes, flush, redirect, busy out)
// Optional feature macro TRAP_VECTORED_MODE_EN: vectored mtvec targets for interrupts.
module rv2t_trap_controller #(
   parameter int XLEN                = 32,
   parameter int PC_BITWIDTH         = 32,
   parameter int EXCEPTION_CODE_BITS = 4
) (
   input logic                    clk,
   input logic                    reset_n,
   input logic                    sync_reset,
   rv2t_trap_controller_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, TRAP, RETURN, WAIT_ACK} state_t;
   // All state lives in one packed struct so both resets clear everything at once.
   typedef struct packed {
      state_t                         state;
      logic                           activate_exception;
      logic                           is_interrupt;
      logic [EXCEPTION_CODE_BITS-1:0] code;
      logic [PC_BITWIDTH-1:0]         exc_pc;
      logic [PC_BITWIDTH-1:0]         exc_addr;
      logic                           mie_clear;
      logic                           mie_restore;
      logic                           flush;
      logic                           redirect_valid;
      logic [PC_BITWIDTH-1:0]         redirect_pc;
      logic                           busy;
   } regs_t;
   regs_t                          regs_q;
   logic                           any_exc;
   logic                           irq_take;
   logic                           misalign;
   logic [EXCEPTION_CODE_BITS-1:0] exc_code;
   logic [XLEN-1:0]                trap_base;
   logic [XLEN-1:0]                trap_target;
   assign any_exc  = bus.exc_illegal | bus.exc_ecall | bus.exc_ebreak |
                     bus.exc_store_misalign | bus.exc_load_misalign;
   assign irq_take = bus.mtip & bus.mtie & bus.mie & bus.int_window;
   assign exc_code = bus.exc_illegal        ? EXCEPTION_CODE_BITS'(2)  :
                     bus.exc_ecall          ? EXCEPTION_CODE_BITS'(11) :
                     bus.exc_ebreak         ? EXCEPTION_CODE_BITS'(3)  :
                     bus.exc_store_misalign ? EXCEPTION_CODE_BITS'(6)  :
                                              EXCEPTION_CODE_BITS'(4);
   // Only a misaligned access that actually won priority reports its address.
   assign misalign  = !bus.exc_illegal && !bus.exc_ecall && !bus.exc_ebreak;
   assign trap_base = bus.mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_MODE_EN
   // Evaluated in TRAP, where the captured cause is already registered.
   assign trap_target = (regs_q.is_interrupt && bus.mtvec[1:0] == 2'b01) ?
                        trap_base + (XLEN'(regs_q.code) << 2) : trap_base;
`else
   assign trap_target = trap_base;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '0;
      end else if (sync_reset) begin
         regs_q <= '0;
      end else begin
         regs_q.activate_exception <= 1'b0;
         regs_q.mie_clear          <= 1'b0;
         regs_q.mie_restore        <= 1'b0;
         regs_q.flush              <= 1'b0;
         case (regs_q.state)
            IDLE: begin
               if (any_exc) begin
                  regs_q.state              <= TRAP;
                  regs_q.busy               <= 1'b1;
                  regs_q.activate_exception <= 1'b1;
                  regs_q.mie_clear          <= 1'b1;
                  regs_q.flush              <= 1'b1;
                  regs_q.is_interrupt       <= 1'b0;
                  regs_q.code               <= exc_code;
                  regs_q.exc_pc             <= bus.exc_pc;
                  regs_q.exc_addr           <= misalign ? bus.exc_addr : '0;
               end else if (irq_take) begin
                  regs_q.state              <= TRAP;
                  regs_q.busy               <= 1'b1;
                  regs_q.activate_exception <= 1'b1;
                  regs_q.mie_clear          <= 1'b1;
                  regs_q.flush              <= 1'b1;
                  regs_q.is_interrupt       <= 1'b1;
                  regs_q.code               <= EXCEPTION_CODE_BITS'(7);
                  regs_q.exc_pc             <= bus.next_pc;
                  regs_q.exc_addr           <= '0;
               end else if (bus.mret_req) begin
                  regs_q.state       <= RETURN;
                  regs_q.busy        <= 1'b1;
                  regs_q.mie_restore <= 1'b1;
                  regs_q.flush       <= 1'b1;
               end
            end
            TRAP: begin
               regs_q.state          <= WAIT_ACK;
               regs_q.redirect_valid <= 1'b1;
               regs_q.redirect_pc    <= PC_BITWIDTH'(trap_target);
            end
            RETURN: begin
               regs_q.state          <= WAIT_ACK;
               regs_q.redirect_valid <= 1'b1;
               regs_q.redirect_pc    <= PC_BITWIDTH'(bus.mepc & ~XLEN'(1));
            end
            WAIT_ACK: begin
               if (bus.redirect_ack) begin
                  regs_q.state          <= IDLE;
                  regs_q.redirect_valid <= 1'b0;
                  regs_q.busy           <= 1'b0;
               end
            end
            default: regs_q.state <= IDLE;
         endcase
      end
   end
   assign bus.activate_exception = regs_q.activate_exception;
   assign bus.is_interrupt       = regs_q.is_interrupt;
   assign bus.exception_code     = regs_q.code;
   assign bus.exception_PC       = regs_q.exc_pc;
   assign bus.exception_addr     = regs_q.exc_addr;
   assign bus.mie_clear          = regs_q.mie_clear;
   assign bus.mie_restore        = regs_q.mie_restore;
   assign bus.flush              = regs_q.flush;
   assign bus.redirect_valid     = regs_q.redirect_valid;
   assign bus.redirect_pc        = regs_q.redirect_pc;
   assign bus.busy               = regs_q.busy;
endmodule
